// File: rtl/cpu_dmem_if_if.sv
// Bundle of CPU-side and memory-side signals for the data-memory interface.
// slave: the cpu_dmem_if block; master: the surrounding CPU/memory environment.
interface cpu_dmem_if_if;
    logic        cpud_request;
    logic        cpud_write;
    logic [31:0] cpud_addr;
    logic [31:0] cpud_wdata;
    logic [3:0]  cpud_byte_en;
    logic        access_deny;
    logic        cpud_ack;
    logic [31:0] cpud_rdata;
    logic        cpud_fault;
    logic [1:0]  cpud_fault_cause;
    logic [31:0] cpud_fault_addr;
    logic        cpud_busy;
    logic        mem_request;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_byte_en;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport slave (
        input  cpud_request, cpud_write, cpud_addr, cpud_wdata, cpud_byte_en,
        input  access_deny, mem_ack, mem_rdata,
        output cpud_ack, cpud_rdata, cpud_fault, cpud_fault_cause, cpud_fault_addr,
        output cpud_busy, mem_request, mem_write, mem_addr, mem_wdata, mem_byte_en
    );

    modport master (
        output cpud_request, cpud_write, cpud_addr, cpud_wdata, cpud_byte_en,
        output access_deny, mem_ack, mem_rdata,
        input  cpud_ack, cpud_rdata, cpud_fault, cpud_fault_cause, cpud_fault_addr,
        input  cpud_busy, mem_request, mem_write, mem_addr, mem_wdata, mem_byte_en
    );
endinterface

// File: rtl/cpu_dmem_if.sv
// CPU data-memory access controller: MPU check, bus issue, wait with timeout.
// Optional alignment checking is enabled by defining DMEM_MISALIGN_CHECK_EN.
module cpu_dmem_if #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input logic          clock,
    input logic          reset,
    cpu_dmem_if_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CHECK, ISSUE, WAIT} state_t;

    localparam logic [7:0] TIMEOUT_LIM = TIMEOUT_CYCLES[7:0];

    state_t     state;
    logic [7:0] wait_cnt;
    logic       misalign;

`ifdef DMEM_MISALIGN_CHECK_EN
    // Each legal lane pattern is tied to exactly one address offset.
    function automatic logic misaligned(input logic [3:0] be, input logic [1:0] a);
        case (be)
            4'b0001: misaligned = (a != 2'b00);
            4'b0010: misaligned = (a != 2'b01);
            4'b0100: misaligned = (a != 2'b10);
            4'b1000: misaligned = (a != 2'b11);
            4'b0011: misaligned = (a != 2'b00);
            4'b1100: misaligned = (a != 2'b10);
            4'b1111: misaligned = (a != 2'b00);
            default: misaligned = 1'b1;
        endcase
    endfunction

    assign misalign = misaligned(bus.mem_byte_en, bus.mem_addr[1:0]);
`else
    assign misalign = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state                <= IDLE;
            wait_cnt             <= '0;
            bus.cpud_ack         <= 1'b0;
            bus.cpud_rdata       <= '0;
            bus.cpud_fault       <= 1'b0;
            bus.cpud_fault_cause <= 2'b00;
            bus.cpud_fault_addr  <= '0;
            bus.cpud_busy        <= 1'b0;
            bus.mem_request      <= 1'b0;
            bus.mem_write        <= 1'b0;
            bus.mem_addr         <= '0;
            bus.mem_wdata        <= '0;
            bus.mem_byte_en      <= '0;
        end else begin
            bus.cpud_ack    <= 1'b0;
            bus.cpud_fault  <= 1'b0;
            bus.mem_request <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.cpud_request) begin
                        bus.mem_write   <= bus.cpud_write;
                        bus.mem_addr    <= bus.cpud_addr;
                        bus.mem_wdata   <= bus.cpud_wdata;
                        bus.mem_byte_en <= bus.cpud_byte_en;
                        bus.cpud_busy   <= 1'b1;
                        state           <= CHECK;
                    end
                end
                CHECK: begin
                    // Alignment fault outranks the MPU verdict.
                    if (misalign || bus.access_deny) begin
                        bus.cpud_fault       <= 1'b1;
                        bus.cpud_fault_cause <= misalign ? 2'b10 : 2'b01;
                        bus.cpud_fault_addr  <= bus.mem_addr;
                        bus.cpud_busy        <= 1'b0;
                        state                <= IDLE;
                    end else begin
                        bus.mem_request <= 1'b1;
                        state           <= ISSUE;
                    end
                end
                ISSUE: begin
                    wait_cnt <= '0;
                    state    <= WAIT;
                end
                WAIT: begin
                    // A completion on the expiry cycle still counts as success.
                    if (bus.mem_ack) begin
                        if (!bus.mem_write)
                            bus.cpud_rdata <= bus.mem_rdata;
                        bus.cpud_ack  <= 1'b1;
                        bus.cpud_busy <= 1'b0;
                        state         <= IDLE;
                    end else if (wait_cnt == TIMEOUT_LIM) begin
                        bus.cpud_fault       <= 1'b1;
                        bus.cpud_fault_cause <= 2'b11;
                        bus.cpud_fault_addr  <= bus.mem_addr;
                        bus.cpud_busy        <= 1'b0;
                        state                <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                default: begin
                    bus.cpud_busy <= 1'b0;
                    state         <= IDLE;
                end
            endcase
        end
    end
endmodule
